// File: rtl/wb_pkg.sv
// Shared types and default sizing for the writeback feed: result request struct
// and the default register count, data width and load-queue depth.
package wb_pkg;

    localparam int WB_XCNT  = 32;
    localparam int WB_XLEN  = 32;
    localparam int WB_DEPTH = 4;
    localparam int WB_SEL_W = $clog2(WB_XCNT);

    typedef struct packed {
        logic [WB_SEL_W-1:0] sel;
        logic [WB_XLEN-1:0]  data;
    } wb_req_t;

    function automatic wb_req_t wb_mk(input logic [WB_SEL_W-1:0] sel,
                                      input logic [WB_XLEN-1:0]  data);
        wb_req_t r;
        r.sel  = sel;
        r.data = data;
        return r;
    endfunction

endpackage

// File: rtl/wb_feed_if.sv
// Load-result queue port bundle: the controller (master) pushes/pops, the queue
// (slave) reports head entry, occupancy and full/empty.
interface wb_fifo_if import wb_pkg::*; #(
    parameter int DEPTH = WB_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          push;
    logic          pop;
    wb_req_t       wr;
    wb_req_t       rd;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    modport master (output push, pop, wr, input rd, full, empty, count);
    modport slave  (input push, pop, wr, output rd, full, empty, count);
endinterface

// File: rtl/wb_fifo.sv
// Circular load-result queue; pointers wrap modulo DEPTH (a power of two),
// count spans 0..DEPTH so full and empty are unambiguous.
module wb_fifo import wb_pkg::*; #(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic     clk,
    input  logic     rst_n,
    wb_fifo_if.slave f
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;
    wb_req_t       mem_q [DEPTH];

    assign f.full  = (count_q == (AW+1)'(DEPTH));
    assign f.empty = (count_q == '0);
    assign f.count = count_q;
    assign f.rd    = mem_q[rptr_q];

    always_comb begin
        do_push = f.push && !f.full;
        do_pop  = f.pop && !f.empty;
        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= f.wr;
    end

endmodule

// File: rtl/wb_feed.sv
// Writeback arbiter: ALU results win, loads queue behind them, and a per-register
// pending scoreboard flags decode hazards. WB_FEED_BYPASS_EN adds forwarding ports.
module wb_feed import wb_pkg::*; #(
    parameter int XCNT  = WB_XCNT,
    parameter int XLEN  = WB_XLEN,
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    ISSUE_VALID,
    input  logic [$clog2(XCNT)-1:0] ISSUE_SEL,
    input  logic                    ALU_VALID,
    input  logic [$clog2(XCNT)-1:0] ALU_SEL,
    input  logic [XLEN-1:0]         ALU_DATA,
    input  logic                    LSU_VALID,
    input  logic [$clog2(XCNT)-1:0] LSU_SEL,
    input  logic [XLEN-1:0]         LSU_DATA,
    output logic                    LSU_READY,
    output logic                    WB_ENABLED,
    output logic [$clog2(XCNT)-1:0] WB_WRITE_SEL,
    output logic [XLEN-1:0]         WB_WRITE_DATA,
    input  logic [$clog2(XCNT)-1:0] READ_SEL1,
    input  logic [$clog2(XCNT)-1:0] READ_SEL2,
    output logic                    WB_HAZARD1,
    output logic                    WB_HAZARD2
`ifdef WB_FEED_BYPASS_EN
   ,output logic                    BYP_VALID1,
    output logic                    BYP_VALID2,
    output logic [XLEN-1:0]         BYP_DATA1,
    output logic [XLEN-1:0]         BYP_DATA2
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_fifo_if #(.DEPTH(DEPTH)) q ();
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (.clk(CLK), .rst_n(RSTN), .f(q.slave));

    logic            alu_hit, lsu_hit, direct;
    logic            wb_en_q, wb_en_d;
    wb_req_t         wb_req_q, wb_req_d;
    logic [XCNT-1:0] pending_q, pending_d;

    // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot.
    assign LSU_READY = (q.count < CW'(DEPTH));

    always_comb begin
        alu_hit = ALU_VALID && (ALU_SEL != '0);
        lsu_hit = LSU_VALID && LSU_READY && (LSU_SEL != '0);
        direct  = lsu_hit && q.empty && !alu_hit;
        q.push  = lsu_hit && !direct;
        q.pop   = !alu_hit && !q.empty;
        q.wr    = wb_mk(LSU_SEL, LSU_DATA);
        wb_en_d = alu_hit || !q.empty || direct;
        if (alu_hit)       wb_req_d = wb_mk(ALU_SEL, ALU_DATA);
        else if (!q.empty) wb_req_d = q.rd;
        else               wb_req_d = q.wr;
    end

    // Clear on the committing write, then set, so a re-issue on the commit cycle wins.
    always_comb begin
        pending_d = pending_q;
        if (wb_en_q) pending_d[wb_req_q.sel] = 1'b0;
        if (ISSUE_VALID && (ISSUE_SEL != '0)) pending_d[ISSUE_SEL] = 1'b1;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            wb_en_q   <= 1'b0;
            wb_req_q  <= '0;
            pending_q <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_req_q  <= wb_req_d;
            pending_q <= pending_d;
        end
    end

    assign WB_ENABLED    = wb_en_q;
    assign WB_WRITE_SEL  = wb_req_q.sel;
    assign WB_WRITE_DATA = wb_req_q.data;

`ifdef WB_FEED_BYPASS_EN
    always_comb begin
        BYP_VALID1 = wb_en_q && (wb_req_q.sel == READ_SEL1) && (READ_SEL1 != '0);
        BYP_VALID2 = wb_en_q && (wb_req_q.sel == READ_SEL2) && (READ_SEL2 != '0);
        BYP_DATA1  = wb_req_q.data;
        BYP_DATA2  = wb_req_q.data;
        WB_HAZARD1 = pending_q[READ_SEL1] && !BYP_VALID1;
        WB_HAZARD2 = pending_q[READ_SEL2] && !BYP_VALID2;
    end
`else
    assign WB_HAZARD1 = pending_q[READ_SEL1];
    assign WB_HAZARD2 = pending_q[READ_SEL2];
`endif

endmodule
